// File: rtl/mem_axi_master_pkg.sv
// Shared request-mode and AXI response encodings for the MMU-to-AXI4-Lite bridge.
package mem_axi_master_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // SLVERR and DECERR both have the upper bit set.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/mem_axi_master.sv
// Single-outstanding MMU request to AXI4-Lite master bridge with registered outputs
// and a sticky bus error flag.
module mem_axi_master
    import mem_axi_master_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      request_enable,
    input  logic                      req_mode,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      response_enable,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      bus_error,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t                    state, state_nxt;
    logic                      response_enable_nxt, bus_error_nxt, busy_nxt;
    logic [DATA_WIDTH-1:0]     resp_data_nxt, wdata_nxt;
    logic [ADDR_WIDTH-1:0]     awaddr_nxt, araddr_nxt;
    logic [DATA_WIDTH/8-1:0]   wstrb_nxt;
    logic                      awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic                      aw_done, w_done;

    assign m_axi_awprot = AXI_PROT;
    assign m_axi_arprot = AXI_PROT;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            response_enable <= 1'b0;
            resp_data       <= '0;
            bus_error       <= 1'b0;
            busy            <= 1'b0;
            m_axi_awaddr    <= '0;
            m_axi_awvalid   <= 1'b0;
            m_axi_wdata     <= '0;
            m_axi_wstrb     <= '0;
            m_axi_wvalid    <= 1'b0;
            m_axi_bready    <= 1'b0;
            m_axi_araddr    <= '0;
            m_axi_arvalid   <= 1'b0;
            m_axi_rready    <= 1'b0;
        end else begin
            state           <= state_nxt;
            response_enable <= response_enable_nxt;
            resp_data       <= resp_data_nxt;
            bus_error       <= bus_error_nxt;
            busy            <= busy_nxt;
            m_axi_awaddr    <= awaddr_nxt;
            m_axi_awvalid   <= awvalid_nxt;
            m_axi_wdata     <= wdata_nxt;
            m_axi_wstrb     <= wstrb_nxt;
            m_axi_wvalid    <= wvalid_nxt;
            m_axi_bready    <= bready_nxt;
            m_axi_araddr    <= araddr_nxt;
            m_axi_arvalid   <= arvalid_nxt;
            m_axi_rready    <= rready_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        response_enable_nxt = 1'b0;
        resp_data_nxt       = resp_data;
        bus_error_nxt       = bus_error;
        awaddr_nxt          = m_axi_awaddr;
        awvalid_nxt         = m_axi_awvalid;
        wdata_nxt           = m_axi_wdata;
        wstrb_nxt           = m_axi_wstrb;
        wvalid_nxt          = m_axi_wvalid;
        bready_nxt          = m_axi_bready;
        araddr_nxt          = m_axi_araddr;
        arvalid_nxt         = m_axi_arvalid;
        rready_nxt          = m_axi_rready;

        case (state)
            IDLE: begin
                if (request_enable) begin
                    awaddr_nxt    = req_addr;
                    araddr_nxt    = req_addr;
                    wdata_nxt     = req_wdata;
                    wstrb_nxt     = req_wstrb;
                    bus_error_nxt = 1'b0;
                    if (req_mode == MEMREQ_READ) begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD_ADDR;
                    end else begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    rready_nxt          = 1'b0;
                    response_enable_nxt = 1'b1;
                    if (resp_is_error(m_axi_rresp)) begin
                        bus_error_nxt = 1'b1;
                        resp_data_nxt = '0;
                    end else begin
                        resp_data_nxt = m_axi_rdata;
                    end
                    state_nxt = DONE;
                end
            end
            WR_REQ: begin
                if (m_axi_awvalid && m_axi_awready) awvalid_nxt = 1'b0;
                if (m_axi_wvalid && m_axi_wready)   wvalid_nxt  = 1'b0;
                if (aw_done && w_done) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid && m_axi_bready) begin
                    bready_nxt          = 1'b0;
                    resp_data_nxt       = '0;
                    response_enable_nxt = 1'b1;
                    if (resp_is_error(m_axi_bresp)) bus_error_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master: vector table of whole transactions against a
// delay-programmable AXI4-Lite slave, plus hand-written latency, reset and ordering cases.
module tb_mem_axi_master;
    import mem_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        request_enable, req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable, bus_error, busy;
    logic [31:0] resp_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    mem_axi_master dut (
        .clk(clk), .rstn(rstn),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data),
        .bus_error(bus_error), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, ar_d, r_d, b_d;
        logic [31:0] rdata;
        logic [1:0]  rresp, bresp;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // slave configuration
    int          aw_d, w_d, ar_d, r_d, b_d;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_rresp, cfg_bresp;

    // observed bus activity
    int          cyc = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, pulse_cnt = 0, pulse_cyc = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, pulse_data = '0;
    logic [3:0]  last_wstrb = '0;
    logic        pulse_err = 1'b0;
    bit          pend_r = 0, pend_b = 0, aw_seen = 0, w_seen = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // handshake monitor: reads pre-edge values at the active edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            pend_r = 0; pend_b = 0; aw_seen = 0; w_seen = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs++; last_awaddr = m_axi_awaddr; aw_seen = 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb; w_seen = 1;
            end
            if (aw_seen && w_seen) begin
                pend_b = 1; aw_seen = 0; w_seen = 0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs++; last_araddr = m_axi_araddr; pend_r = 1;
            end
            if (m_axi_rvalid && m_axi_rready) pend_r = 0;
            if (m_axi_bvalid && m_axi_bready) pend_b = 0;
        end
    end

    // response capture and slave drive on the falling edge
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
        forever begin
            @(negedge clk);
            if (response_enable) begin
                pulse_cnt++; pulse_data = resp_data; pulse_err = bus_error; pulse_cyc = cyc;
            end
            if (!rstn) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_rvalid = 0; m_axi_bvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                if (m_axi_awvalid) begin
                    if (aw_cnt >= aw_d) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt++; end
                end else begin m_axi_awready = 0; aw_cnt = 0; end
                if (m_axi_wvalid) begin
                    if (w_cnt >= w_d) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt++; end
                end else begin m_axi_wready = 0; w_cnt = 0; end
                if (m_axi_arvalid) begin
                    if (ar_cnt >= ar_d) m_axi_arready = 1; else begin m_axi_arready = 0; ar_cnt++; end
                end else begin m_axi_arready = 0; ar_cnt = 0; end
                if (pend_r) begin
                    if (r_cnt >= r_d) begin
                        m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
                    end else r_cnt++;
                end else begin
                    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; r_cnt = 0;
                end
                if (pend_b) begin
                    if (b_cnt >= b_d) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; end
                    else b_cnt++;
                end else begin
                    m_axi_bvalid = 0; m_axi_bresp = '0; b_cnt = 0;
                end
            end
        end
    end

    task automatic set_slave(input vec_t v);
        aw_d = v.aw_d; w_d = v.w_d; ar_d = v.ar_d; r_d = v.r_d; b_d = v.b_d;
        cfg_rdata = v.rdata; cfg_rresp = v.rresp; cfg_bresp = v.bresp;
    endtask

    // Presents a request for one cycle; returns just after the following falling edge.
    task automatic start_req(input logic mode, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        @(negedge clk);
        req_mode = mode; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        request_enable = 1;
        @(negedge clk);
        request_enable = 0;
        #1;
    endtask

    task automatic wait_pulse(input int start_cnt, input string name);
        for (int i = 0; i < 200; i++) begin
            if (pulse_cnt > start_cnt) break;
            @(negedge clk); #1;
        end
        check(name, 32'(pulse_cnt > start_cnt), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int p0, a0, w0, r0;
        set_slave(v);
        p0 = pulse_cnt; a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
        start_req(v.mode, v.addr, v.wdata, v.wstrb);
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d_err_clear", idx), 32'(bus_error), 32'd0);
        wait_pulse(p0, $sformatf("v%0d_done", idx));
        check($sformatf("v%0d_resp_data", idx), pulse_data, v.exp_data);
        check($sformatf("v%0d_bus_error", idx), 32'(pulse_err), 32'(v.exp_err));
        if (v.mode == MEMREQ_READ) begin
            check($sformatf("v%0d_araddr", idx), last_araddr, v.addr);
            check($sformatf("v%0d_ar_count", idx), 32'(ar_hs - r0), 32'd1);
            check($sformatf("v%0d_no_aw", idx), 32'(aw_hs - a0), 32'd0);
        end else begin
            check($sformatf("v%0d_awaddr", idx), last_awaddr, v.addr);
            check($sformatf("v%0d_wdata", idx), last_wdata, v.wdata);
            check($sformatf("v%0d_wstrb", idx), 32'(last_wstrb), 32'(v.wstrb));
            check($sformatf("v%0d_aw_w_count", idx), 32'((aw_hs - a0) + (w_hs - w0)), 32'd2);
        end
    endtask

    vec_t vecs[7];
    vec_t tmp;
    int   p0, r0, c1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          mode          addr          wdata         strb  aw w ar r b rdata         rresp bresp exp_data      err
        vecs[0] = '{MEMREQ_READ,  32'h8000_0010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{MEMREQ_WRITE, 32'h4000_0020, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 32'h0,         2'b00, 2'b00, 32'h0,         1'b0};
        vecs[2] = '{MEMREQ_READ,  32'h8000_0100, 32'h0,        4'h0, 0, 0, 2, 5, 0, 32'h5555_AAAA, 2'b10, 2'b00, 32'h0,         1'b1};
        vecs[3] = '{MEMREQ_READ,  32'h8000_0104, 32'h0,        4'h0, 0, 0, 0, 1, 0, 32'hCAFE_0001, 2'b00, 2'b00, 32'hCAFE_0001, 1'b0};
        vecs[4] = '{MEMREQ_WRITE, 32'h1000_0008, 32'hA5A5_5A5A, 4'hF, 1, 1, 0, 0, 3, 32'h0,         2'b00, 2'b11, 32'h0,         1'b1};
        vecs[5] = '{MEMREQ_WRITE, 32'h1000_000C, 32'h0BAD_F00D, 4'h0, 0, 2, 0, 0, 0, 32'h0,         2'b00, 2'b00, 32'h0,         1'b0};
        vecs[6] = '{MEMREQ_READ,  32'h2000_0000, 32'h0,        4'h0, 4, 4, 1, 0, 0, 32'h0000_00FF, 2'b01, 2'b00, 32'h0000_00FF, 1'b0};

        tmp = vecs[0];
        set_slave(tmp);
        rstn = 0; request_enable = 0; req_mode = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                 m_axi_rready, response_enable, bus_error, busy}), 32'd0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_addr_data", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'd0);
        check("reset_wstrb", 32'(m_axi_wstrb), 32'd0);
        @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);

        // zero-wait read latency, cycle by cycle
        set_slave(vecs[0]);
        start_req(MEMREQ_READ, 32'h8000_0010, 32'h0, 4'h0);
        check("lat_rd_arvalid", 32'(m_axi_arvalid), 32'd1);
        check("lat_rd_araddr", m_axi_araddr, 32'h8000_0010);
        check("lat_rd_arprot", 32'(m_axi_arprot), 32'd0);
        @(negedge clk); #1;
        check("lat_rd_rready", 32'({m_axi_rready, m_axi_arvalid, response_enable}), 32'b100);
        @(negedge clk); #1;
        check("lat_rd_pulse", 32'(response_enable), 32'd1);
        check("lat_rd_data", resp_data, 32'hDEAD_BEEF);
        check("lat_rd_err", 32'(bus_error), 32'd0);
        @(negedge clk); #1;
        check("lat_rd_pulse_end", 32'({response_enable, busy}), 32'd0);

        // zero-wait write latency
        tmp = vecs[1]; tmp.aw_d = 0; set_slave(tmp);
        start_req(MEMREQ_WRITE, 32'h4000_0040, 32'hFEED_0001, 4'hF);
        check("lat_wr_valids", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
        @(negedge clk); #1;
        check("lat_wr_bready", 32'({m_axi_bready, m_axi_awvalid, m_axi_wvalid}), 32'b100);
        @(negedge clk); #1;
        check("lat_wr_pulse", 32'(response_enable), 32'd1);
        check("lat_wr_data", resp_data, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // W completes three cycles ahead of AW
        set_slave(vecs[1]);
        p0 = pulse_cnt;
        start_req(MEMREQ_WRITE, 32'h4000_0020, 32'h1234_5678, 4'b0011);
        check("wfirst_n1", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
        @(negedge clk); #1;
        check("wfirst_n2", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b100);
        @(negedge clk); #1;
        check("wfirst_n3", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b100);
        @(negedge clk); #1;
        check("wfirst_n4", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b100);
        @(negedge clk); #1;
        check("wfirst_n5", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b001);
        wait_pulse(p0, "wfirst_done");
        check("wfirst_resp", pulse_data, 32'd0);

        // second request during RD_DATA is ignored
        tmp = vecs[0]; tmp.r_d = 4; tmp.rdata = 32'h7777_1111; set_slave(tmp);
        p0 = pulse_cnt; r0 = ar_hs;
        start_req(MEMREQ_READ, 32'h1000_0004, 32'h0, 4'h0);
        @(negedge clk);
        request_enable = 1; req_addr = 32'h2000_0000;
        @(negedge clk);
        request_enable = 0;
        #1;
        check("dup_busy", 32'(busy), 32'd1);
        wait_pulse(p0, "dup_done");
        check("dup_busy_in_done", 32'(busy), 32'd1);
        check("dup_data", pulse_data, 32'h7777_1111);
        repeat (6) @(negedge clk);
        #1;
        check("dup_one_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("dup_one_ar", 32'(ar_hs - r0), 32'd1);
        check("dup_araddr", last_araddr, 32'h1000_0004);
        check("dup_idle", 32'(busy), 32'd0);

        // asynchronous reset while AW/W are stalled
        tmp = vecs[1]; tmp.aw_d = 10; tmp.w_d = 10; set_slave(tmp);
        p0 = pulse_cnt;
        start_req(MEMREQ_WRITE, 32'h3000_0000, 32'h1111_2222, 4'hF);
        @(negedge clk); #2;
        check("rst_pre_awvalid", 32'(m_axi_awvalid), 32'd1);
        rstn = 0;
        #1;
        check("rst_async", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready, response_enable, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_no_response", 32'(pulse_cnt - p0), 32'd0);
        tmp = vecs[3]; tmp.rdata = 32'h0102_0304; tmp.exp_data = 32'h0102_0304;
        run_vec(tmp, 10);

        // back-to-back: write issued in the first IDLE cycle after the read's DONE
        tmp = vecs[0]; tmp.rdata = 32'hB2B0_0001; tmp.exp_data = 32'hB2B0_0001;
        run_vec(tmp, 20);
        c1 = pulse_cyc;
        tmp = vecs[1]; tmp.aw_d = 0; tmp.wdata = 32'hB2B0_0002;
        run_vec(tmp, 21);
        check("b2b_gap", 32'(pulse_cyc - c1), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
